// File: rtl/click_tag_arbiter.sv
// Click timestamp tagger: per-channel one-deep capture slots and an epoch
// marker for timestamp wrap. A round-robin arbiter feeds one ready/valid
// output register. The marker always wins over the channel slots.

// One capture slot per channel: holds a timestamp until the arbiter takes it.
module click_tag_slot #(
  parameter int TSW = 28
) (
  input  logic           clock,
  input  logic           reset,
  input  logic           cap,    // click qualified by enable
  input  logic           free,   // slot moves to the output register this cycle
  input  logic [TSW-1:0] ts,
  output logic           pend,
  output logic           lost,
  output logic [TSW-1:0] tsv,
  output logic           loss    // click arrived with nowhere to go
);
  assign loss = cap & pend & ~free;

  // A click refills a slot that is empty or being drained this cycle.
  // Otherwise the click only marks the held stamp as lost.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pend <= 1'b0;
      lost <= 1'b0;
      tsv  <= '0;
    end else if (cap && (!pend || free)) begin
      pend <= 1'b1;
      lost <= 1'b0;
      tsv  <= ts;
    end else begin
      if (loss) lost <= 1'b1;
      if (free) pend <= 1'b0;
    end
  end
endmodule

module click_tag_arbiter #(
  parameter int NCH = 4,
  parameter int TSW = 28
) (
  input  logic           clock,
  input  logic           reset,
  input  logic [NCH-1:0] click_pulse,
  input  logic           enable,
  input  logic           clear,
  output logic [31:0]    out_data,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [NCH-1:0] overflow_flags
);
  localparam int CW = (NCH > 1) ? $clog2(NCH) : 1;

  logic [TSW-1:0]            ts;
  logic [15:0]               epoch;
  logic                      rp, ml;       // rollover pending, marker lost
  logic [CW-1:0]             ptr, gnt, idx;
  logic                      any;
  logic [NCH-1:0]            pend, lost, loss, free, cap;
  logic [NCH-1:0][TSW-1:0]   tsv;
  logic [NCH-1:0][31:0]      chw;
  logic                      load, wrap, take_mk, take_ch;

  assign load    = ~out_valid | out_ready;
  assign wrap    = enable & (&ts);
  assign take_mk = load & rp;
  assign take_ch = load & ~rp & any;
  assign cap     = click_pulse & {NCH{enable}};

  // Per-channel slots and their tag words. Narrow stamps leave room for a
  // 3-bit channel field; wide stamps use bits 30:29 for the channel.
  for (genvar i = 0; i < NCH; i++) begin : g_ch
    click_tag_slot #(.TSW(TSW)) u_slot (
      .clock (clock),
      .reset (reset),
      .cap   (cap[i]),
      .free  (free[i]),
      .ts    (ts),
      .pend  (pend[i]),
      .lost  (lost[i]),
      .tsv   (tsv[i]),
      .loss  (loss[i])
    );
    if (TSW <= 27) begin : g_narrow
      assign chw[i] = {1'b0, 3'(i), lost[i], 27'(tsv[i])};
    end else begin : g_wide
      assign chw[i] = {1'b0, 2'(i), lost[i], tsv[i][27:0]};
    end
  end

  // Round-robin search from ptr. Scan downward so the nearest pending wins.
  always_comb begin
    gnt = ptr;
    any = 1'b0;
    idx = ptr;
    for (int k = NCH - 1; k >= 0; k--) begin
      idx = ptr + CW'(k);
      if (pend[idx]) begin
        gnt = idx;
        any = 1'b1;
      end
    end
  end

  // One-hot release of the granted slot.
  always_comb begin
    free      = '0;
    free[gnt] = take_ch;
  end

  // Timestamp and epoch. Both freeze while disarmed.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ts    <= '0;
      epoch <= '0;
    end else if (enable) begin
      ts <= ts + 1'b1;
      if (&ts) epoch <= epoch + 16'd1;
    end
  end

  // Rollover marker request. A wrap while an unsent marker is pending sets
  // marker-lost, unless that marker leaves in the same cycle.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rp <= 1'b0;
      ml <= 1'b0;
    end else if (wrap) begin
      rp <= 1'b1;
      if (rp && !take_mk) ml <= 1'b1;
      else if (take_mk)   ml <= 1'b0;
    end else if (take_mk) begin
      rp <= 1'b0;
      ml <= 1'b0;
    end
  end

  // Output register. It refills whenever it is empty or being accepted.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (load) begin
      out_valid <= rp | any;
      if (rp)       out_data <= {1'b1, 2'b00, ml, 12'h000, epoch};
      else if (any) out_data <= chw[gnt];
    end
  end

  // Round-robin pointer: next search starts after the last granted channel.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)        ptr <= '0;
    else if (take_ch) ptr <= gnt + 1'b1;
  end

  // Sticky loss flags. A new loss overrides a simultaneous clear.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) overflow_flags <= '0;
    else       overflow_flags <= (clear ? '0 : overflow_flags) | loss;
  end
endmodule

// File: tb/tb_click_tag_arbiter.sv
// Directed bench: vector tables plus hand sequences for wrap and reset cases.
module tb_click_tag_arbiter;
  logic        clock = 1'b0;
  logic        reset;
  logic [3:0]  click_pulse;
  logic        enable, clear, out_ready;
  logic [31:0] out_data;
  logic        out_valid;
  logic [3:0]  overflow_flags;

  // Small-timestamp instance so wraps happen within a short run.
  logic [3:0]  wclick;
  logic        wen, wclr, wready;
  logic [31:0] wdata;
  logic        wvalid;
  logic [3:0]  wovf;

  int n_cmp = 0;
  int n_bad = 0;

  click_tag_arbiter #(.NCH(4), .TSW(28)) dut (
    .clock(clock), .reset(reset), .click_pulse(click_pulse), .enable(enable),
    .clear(clear), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .overflow_flags(overflow_flags)
  );

  click_tag_arbiter #(.NCH(4), .TSW(8)) dut_w (
    .clock(clock), .reset(reset), .click_pulse(wclick), .enable(wen),
    .clear(wclr), .out_data(wdata), .out_valid(wvalid),
    .out_ready(wready), .overflow_flags(wovf)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [3:0]  click;
    logic        en, clr, rdy;
    logic        ev;
    logic [31:0] ed;
    logic [3:0]  eo;
  } vec_t;

  vec_t tab_a[$];
  vec_t tab_b[$];

  function automatic vec_t mk(logic [3:0] c, logic en, logic clr, logic rdy,
                              logic ev, logic [31:0] ed, logic [3:0] eo);
    vec_t v;
    v.click = c; v.en = en; v.clr = clr; v.rdy = rdy;
    v.ev = ev; v.ed = ed; v.eo = eo;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Reset both instances, then arm them. The next edge samples ts=0.
  task automatic do_reset();
    reset = 1'b1; click_pulse = '0; enable = 1'b0; clear = 1'b0; out_ready = 1'b1;
    wclick = '0; wen = 1'b0; wclr = 1'b0; wready = 1'b1;
    tick();
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_data", out_data, 32'd0);
    chk("rst_ovf", 32'(overflow_flags), 32'd0);
    tick();
    reset = 1'b0; enable = 1'b1; wen = 1'b1;
  endtask

  task automatic run_tab(input string name, input vec_t t[$]);
    foreach (t[r]) begin
      click_pulse = t[r].click; enable = t[r].en; clear = t[r].clr; out_ready = t[r].rdy;
      tick();
      chk($sformatf("%s[%0d].valid", name, r), 32'(out_valid), 32'(t[r].ev));
      chk($sformatf("%s[%0d].ovf", name, r), 32'(overflow_flags), 32'(t[r].eo));
      if (t[r].ev) chk($sformatf("%s[%0d].data", name, r), out_data, t[r].ed);
    end
    click_pulse = '0; clear = 1'b0; enable = 1'b1;
  endtask

  initial begin
    reset = 1'b1; click_pulse = '0; enable = 1'b0; clear = 1'b0; out_ready = 1'b1;
    wclick = '0; wen = 1'b0; wclr = 1'b0; wready = 1'b1;

    // A: four simultaneous clicks at ts=5 drain ch0..ch3, still with enable low.
    for (int i = 0; i < 5; i++) tab_a.push_back(mk(4'h0, 1, 0, 1, 0, 0, 4'h0));
    tab_a.push_back(mk(4'hF, 1, 0, 1, 0, 0,            4'h0));
    tab_a.push_back(mk(4'h0, 0, 0, 1, 1, 32'h00000005, 4'h0));
    tab_a.push_back(mk(4'h0, 0, 0, 1, 1, 32'h20000005, 4'h0));
    tab_a.push_back(mk(4'h0, 0, 0, 1, 1, 32'h40000005, 4'h0));
    tab_a.push_back(mk(4'h0, 0, 0, 1, 1, 32'h60000005, 4'h0));
    tab_a.push_back(mk(4'hF, 0, 0, 1, 0, 0,            4'h0));

    // B: ch0 word blocks the output; ch1 at ts=3 waits in its slot.
    // The ch1 click at ts=9 is lost. Clear and a new loss are also exercised.
    tab_b.push_back(mk(4'h1, 1, 0, 0, 0, 0, 4'h0));
    tab_b.push_back(mk(4'h0, 1, 0, 0, 1, 32'h00000000, 4'h0));
    tab_b.push_back(mk(4'h0, 1, 0, 0, 1, 32'h00000000, 4'h0));
    tab_b.push_back(mk(4'h2, 1, 0, 0, 1, 32'h00000000, 4'h0));
    for (int i = 4; i < 9; i++) tab_b.push_back(mk(4'h0, 1, 0, 0, 1, 32'h00000000, 4'h0));
    tab_b.push_back(mk(4'h2, 1, 0, 0, 1, 32'h00000000, 4'h2));
    tab_b.push_back(mk(4'h0, 1, 1, 0, 1, 32'h00000000, 4'h0));
    tab_b.push_back(mk(4'h2, 1, 1, 0, 1, 32'h00000000, 4'h2));
    tab_b.push_back(mk(4'h0, 1, 0, 1, 1, 32'h30000003, 4'h2));
    tab_b.push_back(mk(4'h0, 1, 0, 1, 0, 0,            4'h2));
    tab_b.push_back(mk(4'h0, 1, 1, 1, 0, 0,            4'h0));

    do_reset();
    run_tab("all4", tab_a);
    do_reset();
    run_tab("lost", tab_b);

    // Single ch2 click at ts=0x10: one-cycle-wide word two cycles later.
    do_reset();
    for (int i = 0; i < 16; i++) tick();
    click_pulse = 4'b0100;
    tick();
    click_pulse = '0;
    chk("single.t1_valid", 32'(out_valid), 32'd0);
    tick();
    chk("single.t2_valid", 32'(out_valid), 32'd1);
    chk("single.t2_data", out_data, 32'h40000010);
    tick();
    chk("single.t3_valid", 32'(out_valid), 32'd0);

    // Reset mid-handshake, clicks during reset, then restart from ts=0.
    do_reset();
    out_ready = 1'b0;
    click_pulse = 4'b0001;
    tick();
    click_pulse = '0;
    tick();
    chk("midrst.pre_valid", 32'(out_valid), 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("midrst.async_valid", 32'(out_valid), 32'd0);
    chk("midrst.async_data", out_data, 32'd0);
    tick();
    click_pulse = 4'hF;
    tick();
    click_pulse = '0; reset = 1'b0; enable = 1'b1; out_ready = 1'b1;
    click_pulse = 4'b1000;
    tick();
    click_pulse = '0;
    tick();
    chk("midrst.ch3_valid", 32'(out_valid), 32'd1);
    chk("midrst.ch3_data", out_data, 32'h60000000);
    tick();
    chk("midrst.after_valid", 32'(out_valid), 32'd0);

    // Click on the wrap cycle: marker, then the ch0 word stamped 0xFF.
    do_reset();
    for (int i = 0; i < 255; i++) tick();
    wclick = 4'b0001;
    tick();
    wclick = '0;
    chk("wrap.t1_valid", 32'(wvalid), 32'd0);
    tick();
    chk("wrap.marker_valid", 32'(wvalid), 32'd1);
    chk("wrap.marker_data", wdata, 32'h80000001);
    tick();
    chk("wrap.ch0_valid", 32'(wvalid), 32'd1);
    chk("wrap.ch0_data", wdata, 32'h000000FF);
    tick();
    chk("wrap.idle_valid", 32'(wvalid), 32'd0);

    // Two wraps while the output is blocked: marker-lost set, epoch at 2.
    do_reset();
    wready = 1'b0;
    wclick = 4'b0010;
    tick();
    wclick = '0;
    for (int i = 0; i < 520; i++) tick();
    chk("mlost.hold_valid", 32'(wvalid), 32'd1);
    chk("mlost.hold_data", wdata, 32'h10000000);
    wready = 1'b1;
    tick();
    chk("mlost.marker_valid", 32'(wvalid), 32'd1);
    chk("mlost.marker_data", wdata, 32'h90000002);
    tick();
    chk("mlost.idle_valid", 32'(wvalid), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
